pll_lock_sequencer: RTL and testbench

Controller that sequences the on-chip digital PLL (phase detector, loop filter and DCO) through bring-up.
- Resets the DCO.
- Sweeps the DCO frequency step until the phase error drops.
- Schedules the loop gain from fast to slow as lock quality improves.
- Asserts and monitors lock, re-acquiring when lock is lost.

It sits between the chip I/O configuration pins and the PLL. It drives the PLL's reset, loop_gain and freq_step inputs, and consumes the PLL's phase_error and lead_or_lag outputs.

---
 rtl/pll_lock_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// Bring-up sequencer for the on-chip digital PLL: DCO reset, frequency sweep, loop-gain schedule and lock supervision.
// Define PLL_SEQ_HOLDOVER_EN to add the HOLD state (lock retained for up to 4 windows after a lock loss).
module pll_lock_sequencer #(
    parameter int WIN_LOG2  = 6,
    parameter int ERR_LOCK  = 4,
    parameter int ERR_LOSE  = 16,
    parameter int LOCK_WINS = 4,
    parameter int GAIN_FAST = 1,
    parameter int GAIN_SLOW = 5
) (
    input  logic       i_sys_clk,
    input  logic       i_rst,
    input  logic       i_enable,
    input  logic       i_phase_error,
    input  logic       i_lead_or_lag,
    input  logic [7:0] i_step_min,
    input  logic [7:0] i_step_max,
    output logic [7:0] o_freq_step,
    output logic [2:0] o_loop_gain,
    output logic       o_pll_rst,
    output logic       o_locked,
    output logic [2:0] o_state
);
    localparam int CW = WIN_LOG2 + 1;
    localparam int GW = $clog2(LOCK_WINS + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RSTP   = 3'd1,
        SWEEP  = 3'd2,
        ACQ    = 3'd3,
        LOCKED = 3'd4,
        HOLD   = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic                rstp_q, rstp_d;
    logic [WIN_LOG2-1:0] win_q, win_d;
    logic [CW-1:0]       err_q, err_d, lead_q, lead_d, lag_q, lag_d;
    logic [CW-1:0]       err_now, lead_now, lag_now;
    logic [GW-1:0]       good_cnt_q, good_cnt_d;
    logic [1:0]          miss_q, miss_d;
    logic [7:0]          step_q, step_d;
    logic [2:0]          gain_q, gain_d;
    logic                active, eval, good, bad;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic en);
        if (en && (v != {CW{1'b1}})) return v + CW'(1);
        return v;
    endfunction

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            rstp_q     <= 1'b0;
            win_q      <= '0;
            err_q      <= '0;
            lead_q     <= '0;
            lag_q      <= '0;
            good_cnt_q <= '0;
            miss_q     <= '0;
            step_q     <= i_step_min;
            gain_q     <= 3'(GAIN_FAST);
        end else begin
            state_q    <= state_d;
            rstp_q     <= rstp_d;
            win_q      <= win_d;
            err_q      <= err_d;
            lead_q     <= lead_d;
            lag_q      <= lag_d;
            good_cnt_q <= good_cnt_d;
            miss_q     <= miss_d;
            step_q     <= step_d;
            gain_q     <= gain_d;
        end
    end

    always_comb begin
        active     = (state_q != IDLE) && (state_q != RSTP);
        // The evaluation cycle's own sample is folded into the window result.
        err_now    = sat_inc(err_q, i_phase_error);
        lead_now   = sat_inc(lead_q, i_phase_error & i_lead_or_lag);
        lag_now    = sat_inc(lag_q, i_phase_error & ~i_lead_or_lag);
        eval       = active && (win_q == {WIN_LOG2{1'b1}});
        good       = int'(err_now) <= ERR_LOCK;
        bad        = int'(err_now) > ERR_LOSE;

        state_d    = state_q;
        rstp_d     = rstp_q;
        good_cnt_d = good_cnt_q;
        miss_d     = miss_q;
        step_d     = step_q;
        gain_d     = gain_q;
        win_d      = active ? win_q + WIN_LOG2'(1) : '0;
        err_d      = (active && !eval) ? err_now : '0;
        lead_d     = (active && !eval) ? lead_now : '0;
        lag_d      = (active && !eval) ? lag_now : '0;

        case (state_q)
            IDLE: begin
                step_d = i_step_min;
                gain_d = 3'(GAIN_FAST);
                if (i_enable) begin
                    state_d = RSTP;
                    rstp_d  = 1'b0;
                end
            end
            RSTP: begin
                step_d = i_step_min;
                rstp_d = 1'b1;
                if (rstp_q) begin
                    state_d = SWEEP;
                    rstp_d  = 1'b0;
                end
            end
            SWEEP: begin
                if (eval) begin
                    if (!bad) begin
                        state_d    = ACQ;
                        good_cnt_d = '0;
                    end else if (i_step_min > i_step_max) begin
                        step_d = i_step_min;
                    end else if (lead_now > lag_now) begin
                        step_d = (step_q > i_step_min) ? step_q - 8'd1 : i_step_min;
                    end else begin
                        step_d = (step_q < i_step_max) ? step_q + 8'd1 : i_step_max;
                    end
                end
            end
            ACQ: begin
                if (eval) begin
                    if (good) begin
                        if (int'(good_cnt_q) + 1 == LOCK_WINS) begin
                            good_cnt_d = '0;
                            if (int'(gain_q) < GAIN_SLOW) begin
                                gain_d = gain_q + 3'd1;
                            end else begin
                                state_d = LOCKED;
                                miss_d  = '0;
                            end
                        end else begin
                            good_cnt_d = good_cnt_q + GW'(1);
                        end
                    end else if (bad) begin
                        good_cnt_d = '0;
                        gain_d     = 3'(GAIN_FAST);
                        state_d    = SWEEP;
                    end else begin
                        good_cnt_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (eval) begin
                    if (bad) begin
                        if (miss_q == 2'd1) begin
                            miss_d = '0;
`ifdef PLL_SEQ_HOLDOVER_EN
                            state_d = HOLD;
`else
                            state_d    = ACQ;
                            gain_d     = 3'(GAIN_FAST);
                            good_cnt_d = '0;
`endif
                        end else begin
                            miss_d = miss_q + 2'd1;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
            end
`ifdef PLL_SEQ_HOLDOVER_EN
            HOLD: begin
                if (eval) begin
                    if (good) begin
                        state_d = LOCKED;
                        miss_d  = '0;
                    end else if (miss_q == 2'd3) begin
                        miss_d     = '0;
                        state_d    = ACQ;
                        gain_d     = 3'(GAIN_FAST);
                        good_cnt_d = '0;
                    end else begin
                        miss_d = miss_q + 2'd1;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Dropping the run request overrides every transition above.
        if (!i_enable) begin
            state_d    = IDLE;
            rstp_d     = 1'b0;
            win_d      = '0;
            err_d      = '0;
            lead_d     = '0;
            lag_d      = '0;
            good_cnt_d = '0;
            miss_d     = '0;
            step_d     = i_step_min;
            gain_d     = 3'(GAIN_FAST);
        end
    end

    assign o_freq_step = step_q;
    assign o_loop_gain = gain_q;
    assign o_pll_rst   = (state_q == IDLE) || (state_q == RSTP);
    assign o_locked    = (state_q == LOCKED) || (state_q == HOLD);
    assign o_state     = state_q;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed bring-up scenarios plus randomized traffic against a window-level model.
module tb_pll_lock_sequencer;
    localparam int WIN = 64;
    localparam int M_IDLE = 0, M_RSTP = 1, M_SWEEP = 2, M_ACQ = 3, M_LOCKED = 4, M_HOLD = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       pe  = 1'b0;
    logic       ll  = 1'b0;
    logic [7:0] smin = 8'd10;
    logic [7:0] smax = 8'd40;
    logic [7:0] fstep;
    logic [2:0] gain;
    logic [2:0] st;
    logic       prst;
    logic       lk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: mode follows the published o_state numbering.
    int         m_mode, m_step, m_gain, m_rcnt, m_good, m_miss;
    logic [1:0] m_win[$];

    pll_lock_sequencer dut (
        .i_sys_clk    (clk),
        .i_rst        (rst),
        .i_enable     (en),
        .i_phase_error(pe),
        .i_lead_or_lag(ll),
        .i_step_min   (smin),
        .i_step_max   (smax),
        .o_freq_step  (fstep),
        .o_loop_gain  (gain),
        .o_pll_rst    (prst),
        .o_locked     (lk),
        .o_state      (st)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_eval();
        int  e, ld, lg;
        bit  g, b;
        e = 0; ld = 0; lg = 0;
        foreach (m_win[i]) begin
            if (m_win[i][1]) begin
                e++;
                if (m_win[i][0]) ld++;
                else lg++;
            end
        end
        g = (e <= 4);
        b = (e > 16);
        case (m_mode)
            M_SWEEP: begin
                if (!b) begin
                    m_mode = M_ACQ;
                    m_good = 0;
                end else if (int'(smin) > int'(smax)) m_step = smin;
                else if (ld > lg) m_step = (m_step - 1 < int'(smin)) ? int'(smin) : m_step - 1;
                else m_step = (m_step + 1 > int'(smax)) ? int'(smax) : m_step + 1;
            end
            M_ACQ: begin
                if (g) begin
                    m_good++;
                    if (m_good == 4) begin
                        m_good = 0;
                        if (m_gain < 5) m_gain++;
                        else begin
                            m_mode = M_LOCKED;
                            m_miss = 0;
                        end
                    end
                end else if (b) begin
                    m_good = 0;
                    m_gain = 1;
                    m_mode = M_SWEEP;
                end else m_good = 0;
            end
            M_LOCKED: begin
                if (b) begin
                    m_miss++;
                    if (m_miss == 2) begin
                        m_miss = 0;
`ifdef PLL_SEQ_HOLDOVER_EN
                        m_mode = M_HOLD;
`else
                        m_mode = M_ACQ;
                        m_gain = 1;
                        m_good = 0;
`endif
                    end
                end else m_miss = 0;
            end
            M_HOLD: begin
                if (g) begin
                    m_mode = M_LOCKED;
                    m_miss = 0;
                end else begin
                    m_miss++;
                    if (m_miss == 4) begin
                        m_miss = 0;
                        m_mode = M_ACQ;
                        m_gain = 1;
                        m_good = 0;
                    end
                end
            end
            default: ;
        endcase
    endtask

    // Advances the model by the clock edge about to happen, using the inputs currently applied.
    task automatic model_update();
        if (rst || !en) begin
            m_mode = M_IDLE;
            m_step = smin;
            m_gain = 1;
            m_rcnt = 0;
            m_good = 0;
            m_miss = 0;
            m_win.delete();
            return;
        end
        case (m_mode)
            M_IDLE: begin
                m_step = smin;
                m_gain = 1;
                m_rcnt = 0;
                m_mode = M_RSTP;
            end
            M_RSTP: begin
                m_step = smin;
                m_rcnt++;
                if (m_rcnt == 2) m_mode = M_SWEEP;
            end
            default: begin
                m_win.push_back({pe, ll});
                if (m_win.size() == WIN) begin
                    model_eval();
                    m_win.delete();
                end
            end
        endcase
    endtask

    function automatic logic [15:0] model_vec();
        return {3'(m_mode), (m_mode <= M_RSTP), (m_mode >= M_LOCKED), 3'(m_gain), 8'(m_step)};
    endfunction

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
        check_val("cycle_outputs", 32'({st, prst, lk, gain, fstep}), 32'(model_vec()));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int rst_cycles;
        logic [7:0] step_keep;
        int dens;

        // Reset with run request low.
        rst = 1'b1; en = 1'b0; smin = 8'd10; smax = 8'd40;
        run(3);
        check_val("rst_state", 32'(st), 32'd0);
        check_val("rst_pll_rst", 32'(prst), 32'd1);
        check_val("rst_locked", 32'(lk), 32'd0);
        check_val("rst_gain", 32'(gain), 32'd1);
        check_val("rst_step", 32'(fstep), 32'd10);
        rst = 1'b0;
        run(2);

        // Constant lag errors: sweep upward and saturate at the upper bound.
        en = 1'b1; pe = 1'b1; ll = 1'b0;
        rst_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (st == 3'd1 && prst) rst_cycles++;
        end
        check_val("rstp_cycles", 32'(rst_cycles), 32'd2);
        check_val("sweep_pll_rst", 32'(prst), 32'd0);
        run(WIN * 33);
        check_val("sweep_up_sat", 32'(fstep), 32'd40);
        check_val("sweep_up_state", 32'(st), 32'd2);

        // Constant lead errors: stays pinned at the lower bound.
        en = 1'b0; tick();
        check_val("disable_state", 32'(st), 32'd0);
        en = 1'b1; ll = 1'b1;
        run(2 + WIN * 4);
        check_val("sweep_dn_sat", 32'(fstep), 32'd10);

        // Clean phase: sweep exits, gain schedule runs to lock.
        en = 1'b0; tick();
        en = 1'b1; pe = 1'b0;
        for (int i = 0; i < 3000 && !lk; i++) tick();
        check_val("lock_reached", 32'(lk), 32'd1);
        check_val("lock_gain", 32'(gain), 32'd5);
        check_val("lock_state", 32'(st), 32'd4);

        // One bad window then clean keeps lock.
        for (int i = 0; i < WIN; i++) begin pe = (i < 20); tick(); end
        pe = 1'b0; run(WIN);
        check_val("one_bad_locked", 32'(lk), 32'd1);
        check_val("one_bad_state", 32'(st), 32'd4);

        // Two consecutive bad windows drop lock (or enter holdover).
        step_keep = fstep;
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < WIN; i++) begin pe = (i < 20); tick(); end
        check_val("loss_step", 32'(fstep), 32'(step_keep));
`ifdef PLL_SEQ_HOLDOVER_EN
        check_val("loss_state", 32'(st), 32'd5);
        check_val("loss_locked", 32'(lk), 32'd1);
        check_val("loss_gain", 32'(gain), 32'd5);
`else
        check_val("loss_state", 32'(st), 32'd3);
        check_val("loss_locked", 32'(lk), 32'd0);
        check_val("loss_gain", 32'(gain), 32'd1);
`endif
        for (int w = 0; w < 5; w++)
            for (int i = 0; i < WIN; i++) begin pe = (i < 20); tick(); end
        pe = 1'b0;

        // Disable in the middle of ACQ at gain 3.
        en = 1'b0; tick();
        en = 1'b1;
        for (int i = 0; i < 2000 && !(st == 3'd3 && gain == 3'd3); i++) tick();
        check_val("acq_g3_reached", 32'(gain), 32'd3);
        run(10);
        en = 1'b0; tick();
        check_val("mid_acq_state", 32'(st), 32'd0);
        check_val("mid_acq_pll_rst", 32'(prst), 32'd1);
        check_val("mid_acq_gain", 32'(gain), 32'd1);

        // Randomized traffic with varying error density and bounds.
        en = 1'b1; dens = 0;
        for (int i = 0; i < 5000; i++) begin
            if (i % WIN == 0) begin
                case ($urandom_range(0, 5))
                    0: dens = 0;
                    1: dens = 3;
                    2: dens = 10;
                    3: dens = 25;
                    4: dens = 40;
                    default: dens = 90;
                endcase
            end
            pe = ($urandom_range(0, 99) < dens);
            ll = ($urandom_range(0, 3) != 0) ^ (i / 700 % 2 == 1);
            if ($urandom_range(0, 799) == 0) begin
                en = 1'b0;
                smin = 8'($urandom_range(0, 60));
                smax = 8'($urandom_range(0, 60));
                tick();
                en = 1'b1;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
